instr_mem_unit: RTL and testbench

INSTR_MEM_UNIT -- requirements
Module: instr_mem_unit

---
 rtl/instr_mem_unit.sv | 95 +++++++++
 tb/tb_instr_mem_unit.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_mem_unit.sv
// Instruction memory with a power-on clear sweep, registered fetch port and program-load write port.
// Optional build macro IMEM_MISALIGN_TRAP_EN: misaligned or out-of-range fetches return NOP_WORD with fault set.
module instr_mem_unit #(
    parameter int              DATA_W   = 32,
    parameter int              DEPTH    = 1024,
    parameter logic [DATA_W-1:0] NOP_WORD = '0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     fetch_req,
    input  logic [31:0]              fetch_addr,
    input  logic                     stall,
    output logic [DATA_W-1:0]        instr,
    output logic                     instr_valid,
    input  logic                     prog_we,
    input  logic [$clog2(DEPTH)-1:0] prog_addr,
    input  logic [DATA_W-1:0]        prog_data,
    output logic                     ready,
    output logic                     fault
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic {CLEAR, RUN} state_t;

    state_t            r_state;
    logic [AW-1:0]     r_cnt;
    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_instr;
    logic              r_valid;
    logic              r_fault;
    logic              r_ready;

    logic [AW-1:0]     w_idx;
    logic              w_accept;
    logic              w_bad;

    assign w_idx    = fetch_addr[AW+1:2];
    assign w_accept = (r_state == RUN) && fetch_req && (!stall || !r_valid);

`ifdef IMEM_MISALIGN_TRAP_EN
    assign w_bad = (fetch_addr[1:0] != 2'b00) || (fetch_addr[31:AW+2] != '0);
`else
    // Low and high address bits are dropped so fetches wrap modulo DEPTH.
    logic w_unused_addr;
    assign w_unused_addr = ^{fetch_addr[1:0], fetch_addr[31:AW+2]};
    assign w_bad         = 1'b0;
`endif

    // Single write port: the sweep owns it in CLEAR, the program port in RUN.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (r_state == CLEAR) begin
                r_mem[r_cnt] <= NOP_WORD;
            end else if (prog_we) begin
                r_mem[prog_addr] <= prog_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= CLEAR;
            r_cnt   <= '0;
            r_instr <= NOP_WORD;
            r_valid <= 1'b0;
            r_fault <= 1'b0;
            r_ready <= 1'b0;
        end else begin
            case (r_state)
                CLEAR: begin
                    r_cnt <= r_cnt + AW'(1);
                    if (r_cnt == AW'(DEPTH - 1)) begin
                        r_state <= RUN;
                        r_ready <= 1'b1;
                    end
                end
                RUN: begin
                    if (w_accept) begin
                        r_instr <= w_bad ? NOP_WORD : r_mem[w_idx];
                        r_valid <= 1'b1;
                        r_fault <= w_bad;
                    end else if (!fetch_req && !stall) begin
                        r_valid <= 1'b0;
                    end
                end
                default: r_state <= CLEAR;
            endcase
        end
    end

    assign instr       = r_instr;
    assign instr_valid = r_valid;
    assign fault       = r_fault;
    assign ready       = r_ready;
endmodule

// File: tb/tb_instr_mem_unit.sv
// Self-checking bench for instr_mem_unit (DEPTH=16): directed scenarios plus randomized traffic
// against an array-based reference model.
module tb_instr_mem_unit;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 16;
    localparam logic [31:0] NOP = 32'h0;

    logic        clk = 1'b0;
    logic        rst, fetch_req, stall, prog_we;
    logic [31:0] fetch_addr;
    logic [3:0]  prog_addr;
    logic [31:0] prog_data;
    logic [31:0] instr;
    logic        instr_valid, ready, fault;

    int errors = 0;
    int checks = 0;

    logic [31:0] model_mem [DEPTH];
    logic [31:0] exp_instr;
    logic        exp_valid, exp_fault;

    instr_mem_unit #(.DATA_W(DATA_W), .DEPTH(DEPTH), .NOP_WORD(NOP)) dut (
        .clk(clk), .rst(rst), .fetch_req(fetch_req), .fetch_addr(fetch_addr),
        .stall(stall), .instr(instr), .instr_valid(instr_valid),
        .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
        .ready(ready), .fault(fault)
    );

    always #5 clk = ~clk;

    // Advance one rising edge; outputs are sampled and inputs driven 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic addr_bad(input logic [31:0] a);
`ifdef IMEM_MISALIGN_TRAP_EN
        return (a[1:0] != 2'b00) || (a >= 32'(4 * DEPTH));
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [31:0] fetch_expect(input logic [31:0] a);
        if (addr_bad(a)) return NOP;
        return model_mem[(a / 4) % DEPTH];
    endfunction

    task automatic count_sweep(input string name);
        int n = 0;
        while (!ready && n < 100) begin
            n++;
            tick();
        end
        checks++;
        if (n !== DEPTH) begin
            errors++;
            $display("FAIL %s: ready low for %0d cycles, required %0d", name, n, DEPTH);
        end else $display("%s: ready low for %0d cycles", name, n);
        foreach (model_mem[i]) model_mem[i] = NOP;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if ({instr, instr_valid, fault, ready} !== {NOP, 1'b0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_state: instr=%h valid=%b fault=%b ready=%b, required %h 0 0 0",
                     instr, instr_valid, fault, ready, NOP);
        end else $display("reset_state ok");
        count_sweep("reset_sweep");
    endtask

    task automatic test_clear_contents();
        for (int a = 0; a <= 60; a += 4) begin
            fetch_req = 1'b1; fetch_addr = 32'(a);
            tick();
            checks++;
            if (instr !== NOP || instr_valid !== 1'b1) begin
                errors++;
                $display("FAIL clear_fetch addr %h: instr=%h valid=%b, required %h 1", a, instr, instr_valid, NOP);
            end else $display("clear_fetch addr %h -> %h", a, instr);
        end
        fetch_req = 1'b0;
        tick();
    endtask

    task automatic prog(input logic [3:0] idx, input logic [31:0] data);
        prog_we = 1'b1; prog_addr = idx; prog_data = data;
        tick();
        prog_we = 1'b0;
        model_mem[idx] = data;
    endtask

    task automatic test_program_fetch();
        prog(4'd5, 32'h012A5020);
        prog(4'd6, 32'h11112222);
        fetch_req = 1'b1; fetch_addr = 32'h14;
        tick();
        fetch_req = 1'b0;
        checks++;
        if (instr !== 32'h012A5020 || instr_valid !== 1'b1) begin
            errors++;
            $display("FAIL program_fetch: instr=%h valid=%b, required 012a5020 1", instr, instr_valid);
        end else $display("program_fetch 0x14 -> %h", instr);
    endtask

    task automatic test_stall();
        fetch_req = 1'b1; fetch_addr = 32'h14; stall = 1'b0;
        tick();
        stall = 1'b1; fetch_addr = 32'h18;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (instr !== 32'h012A5020 || instr_valid !== 1'b1) begin
                errors++;
                $display("FAIL stall_hold cycle %0d: instr=%h valid=%b, required 012a5020 1", i, instr, instr_valid);
            end else $display("stall_hold cycle %0d instr=%h", i, instr);
        end
        stall = 1'b0;
        tick();
        fetch_req = 1'b0;
        checks++;
        if (instr !== model_mem[6]) begin
            errors++;
            $display("FAIL stall_release: instr=%h, required %h", instr, model_mem[6]);
        end else $display("stall_release instr=%h", instr);
        tick();
    endtask

    task automatic test_rbw();
        fetch_req = 1'b1; fetch_addr = 32'h14;
        prog_we = 1'b1; prog_addr = 4'd5; prog_data = 32'hDEADBEEF;
        tick();
        prog_we = 1'b0;
        model_mem[5] = 32'hDEADBEEF;
        checks++;
        if (instr !== 32'h012A5020) begin
            errors++;
            $display("FAIL rbw_old: instr=%h, required 012a5020", instr);
        end else $display("rbw_old instr=%h", instr);
        tick();
        fetch_req = 1'b0;
        checks++;
        if (instr !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL rbw_new: instr=%h, required deadbeef", instr);
        end else $display("rbw_new instr=%h", instr);
    endtask

    task automatic test_addr_bounds();
        logic [31:0] addrs [2];
        logic [31:0] held;
        addrs[0] = 32'h40;
        addrs[1] = 32'h15;
        prog(4'd0, 32'hA5A50001);
        for (int i = 0; i < 2; i++) begin
            fetch_req = 1'b1; fetch_addr = addrs[i];
            tick();
            checks++;
            if (instr !== fetch_expect(addrs[i]) || fault !== addr_bad(addrs[i]) || instr_valid !== 1'b1) begin
                errors++;
                $display("FAIL addr_bound %h: instr=%h fault=%b valid=%b, required %h %b 1",
                         addrs[i], instr, fault, instr_valid, fetch_expect(addrs[i]), addr_bad(addrs[i]));
            end else $display("addr_bound %h -> %h fault=%b", addrs[i], instr, fault);
        end
        held = instr;
        fetch_req = 1'b0;
        tick();
        checks++;
        if (instr_valid !== 1'b0 || instr !== held) begin
            errors++;
            $display("FAIL idle_invalidate: valid=%b instr=%h, required 0 %h", instr_valid, instr, held);
        end else $display("idle_invalidate ok");
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 8; i++) prog(4'(i + 8), $urandom);
        for (int i = 8; i < 16; i++) begin
            fetch_req = 1'b1; fetch_addr = 32'(i * 4);
            tick();
            checks++;
            if (instr !== model_mem[i] || instr_valid !== 1'b1) begin
                errors++;
                $display("FAIL back_to_back idx %0d: instr=%h valid=%b, required %h 1", i, instr, instr_valid, model_mem[i]);
            end else $display("back_to_back idx %0d -> %h", i, instr);
        end
        fetch_req = 1'b0;
        tick();
    endtask

    task automatic test_random();
        exp_valid = 1'b0;
        exp_fault = 1'b0;
        exp_instr = instr;
        for (int n = 0; n < 300; n++) begin
            fetch_req  = (n == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
            stall      = (n == 0) ? 1'b0 : ($urandom_range(0, 9) < 3);
            fetch_addr = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, DEPTH - 1) * 4);
            prog_we    = ($urandom_range(0, 2) == 0);
            prog_addr  = 4'($urandom);
            prog_data  = $urandom;
            if (fetch_req && (!stall || !exp_valid)) begin
                exp_instr = fetch_expect(fetch_addr);
                exp_fault = addr_bad(fetch_addr);
                exp_valid = 1'b1;
            end else if (!fetch_req && !stall) begin
                exp_valid = 1'b0;
            end
            if (prog_we) model_mem[prog_addr] = prog_data;
            tick();
            checks++;
            if (instr !== exp_instr || instr_valid !== exp_valid || fault !== exp_fault || ready !== 1'b1) begin
                errors++;
                $display("FAIL random #%0d: instr=%h valid=%b fault=%b ready=%b, required %h %b %b 1",
                         n, instr, instr_valid, fault, ready, exp_instr, exp_valid, exp_fault);
            end else $display("random #%0d req=%b stall=%b addr=%h we=%b -> instr=%h valid=%b",
                              n, fetch_req, stall, fetch_addr, prog_we, instr, instr_valid);
        end
        fetch_req = 1'b0; stall = 1'b0; prog_we = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid_sweep();
        prog(4'd5, 32'h0BADF00D);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (instr_valid !== 1'b0 || instr !== NOP || ready !== 1'b0) begin
            errors++;
            $display("FAIL run_reset: valid=%b instr=%h ready=%b, required 0 %h 0", instr_valid, instr, ready, NOP);
        end else $display("run_reset ok");
        for (int i = 0; i < 7; i++) tick();
        checks++;
        if (ready !== 1'b0) begin
            errors++;
            $display("FAIL mid_sweep_ready: ready=%b, required 0", ready);
        end else $display("mid_sweep at index 7, ready low");
        rst = 1'b1;
        tick();
        rst = 1'b0;
        count_sweep("restart_sweep");
        fetch_req = 1'b1; fetch_addr = 32'h14;
        tick();
        fetch_req = 1'b0;
        checks++;
        if (instr !== NOP) begin
            errors++;
            $display("FAIL resweep_clear: instr=%h, required %h", instr, NOP);
        end else $display("resweep_clear idx5 -> %h", instr);
    endtask

    initial begin
        rst = 1'b1; fetch_req = 1'b0; fetch_addr = '0; stall = 1'b0;
        prog_we = 1'b0; prog_addr = '0; prog_data = '0;
        test_reset();
        test_clear_contents();
        test_program_fetch();
        test_stall();
        test_rbw();
        test_addr_bounds();
        test_back_to_back();
        test_random();
        test_reset_mid_sweep();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
